seq_scan_ctrl: RTL and testbench
================================

# seq_scan_ctrl

Job controller for bit-serial pattern detection. It accepts parallel words over a valid/ready handshake and serializes each word MSB-first into an internal programmable sequence detector (pattern up to PW bits, overlapping or non-overlapping). It counts matches over a job of `num_words` words and reports completion. It sequences the detector datapath so that software-style configuration replaces per-pattern hardcoded FSMs such as the 11011 detector.

## Interface
- `DW`, 8, input word width (bits serialized per word)
- `PW`, 8, maximum pattern length
- `CW`, 16, match counter width
- `clk`  in  1  rising-edge clock
- `rst_n`  in  1  reset, asynchronous assert, active-low
- `cfg_pattern`  in  PW  pattern; bit [len-1] is the first bit expected, bit [0] the last
- `cfg_len`  in  clog2(PW)+1  pattern length, 1..PW
- `cfg_overlap`  in  1  1 = overlapping matches allowed
- `num_words`  in  8  words in the job
- `start`  in  1  job start pulse, sampled in IDLE only
- `in_valid` / `in_data`  in  1 / DW  word input
- `in_ready`  out  1  word accepted when `in_valid && in_ready`
- `z`  out  1  one-cycle match pulse
- `busy`  out  1  job in progress (not IDLE)
- `done`  out  1  one-cycle job-complete pulse
- `match_count`  out  CW  matches in current/last job

## Operation
- Reset values: state IDLE, `in_ready`=0, `z`=0, `busy`=0, `done`=0, `match_count`=0, history/bit-count/word-count=0.
- **IDLE:**
  - On `start`, latch `cfg_*` and `num_words`, clear history, bit count and `match_count`, then go to LOAD.
  - If `num_words`==0, go to DONE instead.
- **LOAD:**
  - `in_ready`=1. On handshake, latch `in_data` into the shift register, then go to SHIFT.
  - `in_valid` low stalls in LOAD indefinitely.
- **SHIFT:**
  - Lasts DW cycles. Each cycle, shift the MSB into the history (PW bits, newest at [0]).
  - Bit count increments, saturating at PW.
  - After the DW-th bit, go to LOAD if words remain, else go to DONE.
- **DONE:** `done`=1 for one cycle, then go to IDLE. `match_count` holds until the next `start`.
- **Detection:**
  - A match is `next_bitcount >= len && next_hist[len-1:0] == pattern[len-1:0]`.
  - `z` is registered from the match, so it is high the cycle after the SHIFT cycle that consumed the final pattern bit. `match_count` increments on the same edge.
- **Overlap mode:**
  - `cfg_overlap`=1: history is retained after a match.
  - `cfg_overlap`=0: bit count is cleared to 0 on the match edge, so the next match needs len fresh bits.
- History and bit count persist across word boundaries within a job, so patterns may span words.
- **Length handling:** `cfg_len`=0 yields no matches. `cfg_len` > PW is clamped to PW.
- `match_count` saturates at 2^CW-1; `z` still pulses.
- `start` while busy is ignored. Config changes mid-job have no effect.
- `rst_n` low at any time, including mid-SHIFT, immediately forces the reset values. No partial job state survives.

## Timing
- Word acceptance to first shifted bit: 1 cycle.
- Throughput: DW+1 cycles per word with `in_valid` held high.
- Bit i (0-indexed) of word w is consumed in SHIFT cycle i.
- A match on the final bit of the job gives `z` in the DONE cycle, and `match_count` is final when `done`=1.
- `start` with `num_words`=0: `busy` high one cycle later, `done` the cycle after that.
- Job of N words, no stalls: `done` asserts N*(DW+1)+1 cycles after the `start` edge.
- `busy` deasserts the cycle after `done`.

## Test plan
- **Overlap on:** pattern 11011, len 5, one word 0xDB.
  - `z` pulses after bit 4 and bit 7.
  - `done` with `match_count`=2.
- **Overlap off:** same stimulus as the overlap-on case.
  - Single `z` after bit 4.
  - `match_count`=1.
- **Cross-word match:** pattern 11011, words 0x03 then 0x60.
  - One `z` after bit 2 of the second word.
  - `match_count`=1.
  - `in_ready` low during SHIFT; stalling `in_valid` for 5 cycles delays `done` by 5.
- **Saturation:** CW=2, pattern 1, len 1, word 0xFF.
  - 8 `z` pulses.
  - `match_count` sticks at 3.
- **Empty job and ignored start:** `num_words`=0.
  - `done` 2 cycles after `start`, `match_count`=0.
  - A second `start` during an active job is ignored and `match_count` is unaffected.
- **Reset mid-SHIFT:** drop `rst_n` mid-SHIFT.
  - All outputs 0 immediately.
  - After release, a fresh 0xDB job (overlap on) reports 2.

Source files
------------

// File: rtl/seq_scan_ctrl_if.sv
// Word-input handshake for seq_scan_ctrl: producer drives valid/data, controller drives ready.
// Zero latency; a word transfers on any cycle with in_valid && in_ready.
interface seq_scan_ctrl_if #(
    parameter int DW = 8
);
    logic          in_valid;
    logic [DW-1:0] in_data;
    logic          in_ready;

    modport master (output in_valid, output in_data, input  in_ready);
    modport slave  (input  in_valid, input  in_data, output in_ready);
endinterface

// File: rtl/seq_scan_ctrl.sv
// Job controller: serializes words MSB-first into a programmable pattern detector and counts matches.
// DW+1 cycles per word, z one cycle after the matching bit; in_ready drops for the whole SHIFT phase.
module seq_scan_ctrl #(
    parameter int DW = 8,
    parameter int PW = 8,
    parameter int CW = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [PW-1:0]        cfg_pattern,
    input  logic [$clog2(PW):0]  cfg_len,
    input  logic                 cfg_overlap,
    input  logic [7:0]           num_words,
    input  logic                 start,
    seq_scan_ctrl_if.slave       in_if,
    output logic                 z,
    output logic                 busy,
    output logic                 done,
    output logic [CW-1:0]        match_count
);
    localparam int LW  = $clog2(PW) + 1;
    localparam int SCW = (DW > 1) ? $clog2(DW) : 1;

    typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;

    state_t          state;
    logic [PW-1:0]   pat_q;
    logic [LW-1:0]   len_q;
    logic            ovl_q;
    logic [7:0]      words_left;
    logic [DW-1:0]   shreg;
    logic [SCW-1:0]  shcnt;
    logic [PW-1:0]   hist;
    logic [LW-1:0]   bitcnt;

    logic [PW-1:0]   hist_nxt;
    logic [LW-1:0]   bc_nxt;
    logic [PW-1:0]   mask;
    logic            match;

    // Detector sees the history and bit count as they will be after this bit.
    always_comb begin
        hist_nxt = {hist[PW-2:0], shreg[DW-1]};
        bc_nxt   = (bitcnt == LW'(PW)) ? bitcnt : bitcnt + LW'(1);
        mask     = '0;
        if (len_q != '0)
            mask = {PW{1'b1}} >> (LW'(PW) - len_q);
        match    = (len_q != '0) && (bc_nxt >= len_q) &&
                   ((hist_nxt & mask) == (pat_q & mask));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            pat_q          <= '0;
            len_q          <= '0;
            ovl_q          <= 1'b0;
            words_left     <= '0;
            shreg          <= '0;
            shcnt          <= '0;
            hist           <= '0;
            bitcnt         <= '0;
            in_if.in_ready <= 1'b0;
            z              <= 1'b0;
            busy           <= 1'b0;
            done           <= 1'b0;
            match_count    <= '0;
        end else begin
            z    <= 1'b0;
            done <= 1'b0;
            case (state)
                IDLE: begin
                    busy <= start;
                    if (start) begin
                        pat_q       <= cfg_pattern;
                        len_q       <= (cfg_len > LW'(PW)) ? LW'(PW) : cfg_len;
                        ovl_q       <= cfg_overlap;
                        words_left  <= num_words;
                        hist        <= '0;
                        bitcnt      <= '0;
                        match_count <= '0;
                        if (num_words == 8'd0) begin
                            state <= DONE;
                        end else begin
                            state          <= LOAD;
                            in_if.in_ready <= 1'b1;
                        end
                    end
                end
                LOAD: begin
                    if (in_if.in_valid) begin
                        shreg          <= in_if.in_data;
                        shcnt          <= '0;
                        in_if.in_ready <= 1'b0;
                        state          <= SHIFT;
                    end
                end
                SHIFT: begin
                    shreg  <= shreg << 1;
                    hist   <= hist_nxt;
                    bitcnt <= (match && !ovl_q) ? '0 : bc_nxt;
                    shcnt  <= shcnt + SCW'(1);
                    if (match) begin
                        z <= 1'b1;
                        if (match_count != '1)
                            match_count <= match_count + CW'(1);
                    end
                    if (shcnt == SCW'(DW - 1)) begin
                        words_left <= words_left - 8'd1;
                        if (words_left == 8'd1) begin
                            state <= DONE;
                        end else begin
                            state          <= LOAD;
                            in_if.in_ready <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    // busy stays high through the done pulse and drops one cycle later
                    done  <= 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_seq_scan_ctrl.sv
// Scoreboard bench for seq_scan_ctrl: a main instance (CW=16) and a saturation instance (CW=2)
// share all stimulus; monitors check match_count, z pulse count and done latency on every done.
module tb_seq_scan_ctrl;
    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] cfg_pattern;
    logic [3:0] cfg_len;
    logic       cfg_overlap;
    logic [7:0] num_words;
    logic       start;

    logic        z, busy, done;
    logic [15:0] match_count;
    logic        z2, busy2, done2;
    logic [1:0]  mc2;

    seq_scan_ctrl_if #(.DW(8)) ifc ();
    seq_scan_ctrl_if #(.DW(8)) sif ();
    assign sif.in_valid = ifc.in_valid;
    assign sif.in_data  = ifc.in_data;

    seq_scan_ctrl #(.DW(8), .PW(8), .CW(16)) u_dut (
        .clk(clk), .rst_n(rst_n), .cfg_pattern(cfg_pattern), .cfg_len(cfg_len),
        .cfg_overlap(cfg_overlap), .num_words(num_words), .start(start), .in_if(ifc),
        .z(z), .busy(busy), .done(done), .match_count(match_count));

    seq_scan_ctrl #(.DW(8), .PW(8), .CW(2)) u_sat (
        .clk(clk), .rst_n(rst_n), .cfg_pattern(cfg_pattern), .cfg_len(cfg_len),
        .cfg_overlap(cfg_overlap), .num_words(num_words), .start(start), .in_if(sif),
        .z(z2), .busy(busy2), .done(done2), .match_count(mc2));

    always #5 clk = ~clk;

    typedef struct {
        int cnt;
        int zc;
        int lat;
    } exp_t;

    exp_t exp_q[$];
    exp_t sat_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic chk(input string nm, input longint act, input longint exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Main monitor
    int zc = 0, lt = 0;
    bit pb = 0, pd = 0;
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            zc = 0; lt = 0; pb = 0; pd = 0;
        end else begin
            if (pd) chk("busy_after_done", busy, 0);
            lt = (busy && !pb) ? 0 : lt + 1;
            if (z) zc++;
            if (done) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_done", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("match_count", match_count, e.cnt);
                    chk("z_pulses", zc, e.zc);
                    chk("done_latency", lt, e.lat);
                end
                zc = 0;
            end
            pb = busy;
            pd = done;
        end
    end

    // Saturation-instance monitor
    int zc2 = 0;
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            zc2 = 0;
        end else begin
            if (z2) zc2++;
            if (done2) begin
                if (sat_q.size() == 0) begin
                    chk("sat_unexpected_done", 1, 0);
                end else begin
                    e = sat_q.pop_front();
                    chk("sat_match_count", mc2, e.cnt);
                    chk("sat_z_pulses", zc2, e.zc);
                end
                zc2 = 0;
            end
        end
    end

    task automatic push_exp(input int nw, input int stall, input int cnt, input int zp);
        exp_q.push_back('{cnt, zp, nw * 9 + 1 + stall});
        sat_q.push_back('{(cnt > 3) ? 3 : cnt, zp, 0});
    endtask

    task automatic feed_word(input logic [7:0] w, input int stall, input bit poke);
        int t;
        ifc.in_data = w;
        t = 0;
        @(negedge clk);
        while (!ifc.in_ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (!ifc.in_ready) chk("ready_timeout", 0, 1);
        for (int s = 0; s < stall; s++) begin
            if (poke && s == 0) begin
                start = 1'b1; num_words = 8'd0; cfg_pattern = 8'h01; cfg_len = 4'd1;
            end
            @(posedge clk);
            #1 start = 1'b0;
        end
        ifc.in_valid = 1'b1;
        @(posedge clk);
        #1 ifc.in_valid = 1'b0;
        chk("in_ready_in_shift", ifc.in_ready, 0);
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        while (busy && t < 300) begin
            @(negedge clk);
            t++;
        end
        if (busy) chk("done_timeout", 0, 1);
        @(negedge clk);
    endtask

    task automatic run_job(input logic [7:0] pat, input logic [3:0] len, input logic ovl,
                           input int nw, input logic [7:0] w0, input logic [7:0] w1,
                           input int stall, input bit poke, input int cnt, input int zp);
        cfg_pattern = pat; cfg_len = len; cfg_overlap = ovl; num_words = nw[7:0];
        push_exp(nw, stall, cnt, zp);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        for (int k = 0; k < nw; k++)
            feed_word((k == 0) ? w0 : w1, (k > 0) ? stall : 0, poke);
        wait_idle();
        chk("match_count_hold", match_count, cnt);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; start = 1'b0; cfg_pattern = '0; cfg_len = '0; cfg_overlap = 1'b0;
        num_words = '0; ifc.in_valid = 1'b0; ifc.in_data = '0;
        repeat (2) @(negedge clk);
        chk("rst_in_ready", ifc.in_ready, 0);
        chk("rst_z", z, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_match_count", match_count, 0);
        rst_n = 1'b1;
        @(negedge clk);

        run_job(8'h1B, 4'd5, 1'b1, 1, 8'hDB, 8'h00, 0, 1'b0, 2, 2);   // overlap on
        run_job(8'h1B, 4'd5, 1'b0, 1, 8'hDB, 8'h00, 0, 1'b0, 1, 1);   // overlap off
        run_job(8'h1B, 4'd5, 1'b1, 2, 8'h03, 8'h60, 0, 1'b0, 1, 1);   // spans words
        run_job(8'h1B, 4'd5, 1'b1, 2, 8'h03, 8'h60, 5, 1'b1, 1, 1);   // stall + ignored start
        run_job(8'h01, 4'd1, 1'b1, 1, 8'hFF, 8'h00, 0, 1'b0, 8, 8);   // sat instance sticks at 3
        run_job(8'hDB, 4'd15, 1'b1, 1, 8'hDB, 8'h00, 0, 1'b0, 1, 1);  // len clamped to 8
        run_job(8'h1B, 4'd0, 1'b1, 1, 8'hDB, 8'h00, 0, 1'b0, 0, 0);   // len 0: no matches

        // Empty job: busy one cycle after start, done the cycle after that
        cfg_pattern = 8'h1B; cfg_len = 4'd5; cfg_overlap = 1'b1; num_words = 8'd0;
        push_exp(0, 0, 0, 0);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        chk("empty_busy_c1", busy, 1);
        chk("empty_done_c1", done, 0);
        @(posedge clk);
        #1;
        chk("empty_done_c2", done, 1);
        chk("empty_busy_c2", busy, 1);
        @(posedge clk);
        #1;
        chk("empty_busy_c3", busy, 0);
        chk("empty_match_count", match_count, 0);
        @(negedge clk);

        // Reset mid-SHIFT: aborted job gets no scoreboard entry
        cfg_pattern = 8'h1B; cfg_len = 4'd5; cfg_overlap = 1'b1; num_words = 8'd1;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        feed_word(8'hDB, 0, 1'b0);
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_in_ready", ifc.in_ready, 0);
        chk("arst_z", z, 0);
        chk("arst_busy", busy, 0);
        chk("arst_done", done, 0);
        chk("arst_match_count", match_count, 0);
        chk("arst_sat_busy", busy2, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_job(8'h1B, 4'd5, 1'b1, 1, 8'hDB, 8'h00, 0, 1'b0, 2, 2);

        repeat (5) @(negedge clk);
        chk("scoreboard_drained", exp_q.size(), 0);
        chk("sat_scoreboard_drained", sat_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
